alu_req_arbiter: RTL and testbench

//   Shares one ALU between two requesters: round-robin arbitration, one outstanding op.

---
 rtl/alu_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters with round-robin grant and one outstanding op.
// Latency: 3 cycles best case from accept to rsp_valid (accept, alu_en, result sample).
// Backpressure: rsp_valid holds with stable id/data/err until rsp_ready; no accepts until IDLE.
//
// Ports:
//   CLK, RST                 clock (rising edge), synchronous active-low reset
//   reqN_valid/ready/a/b/fun command channel of requester N (N = 0, 1)
//   alu_a/b/fun, alu_en      registered operands, function code and one-cycle strobe to ALU
//   alu_out, alu_out_valid   ALU result return
//   rsp_valid/ready          response handshake; rsp_id/data/err carry the result
//   busy                     operation in progress (state != IDLE)
module alu_req_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [3:0]         req0_fun,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [3:0]         req1_fun,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_fun,
  output logic               alu_en,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_out_valid,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t               state_q, state_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic                 id_q, id_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [3:0]           alu_fun_q, alu_fun_d;
  logic                 alu_en_q, alu_en_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;

  logic grant;   // 0 = requester 0, 1 = requester 1
  logic accept;

  // Pointer only matters under contention; a lone requester always wins.
  assign grant  = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
  // Readies are gated by reset so nothing looks accepted while RST is low.
  assign accept = RST && (state_q == S_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    timer_d     = timer_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    alu_en_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          alu_a_d   = grant ? req1_a : req0_a;
          alu_b_d   = grant ? req1_b : req0_b;
          alu_fun_d = grant ? req1_fun : req0_fun;
          id_d      = grant;
          rr_ptr_d  = ~grant;
          alu_en_d  = 1'b1;          // strobe is high during ISSUE
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the timeout cycle still counts as a good result.
        if (alu_out_valid) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = alu_out;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;        // id/data/err keep their last values
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 1'b0;
      id_q        <= 1'b0;
      timer_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      alu_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      timer_q     <= timer_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      alu_en_q    <= alu_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fun   = alu_fun_q;
  assign alu_en    = alu_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed vector table, hand-written corner sequences,
// and randomized operations checked against a transaction-level model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_alu_req_arbiter;

  localparam int W  = 16;
  localparam int TO = 15;

  logic          CLK, RST;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [3:0]    req0_fun, req1_fun;
  logic [W-1:0]  alu_a, alu_b;
  logic [3:0]    alu_fun;
  logic          alu_en;
  logic [2*W-1:0] alu_out;
  logic          alu_out_valid;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [2*W-1:0] rsp_data;

  alu_req_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_en(alu_en),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic model_ptr;   // round-robin pointer of the reference model

  typedef struct {
    logic v0, v1;
    logic [15:0] a0, b0; logic [3:0] f0;
    logic [15:0] a1, b1; logic [3:0] f1;
    int dly;            // WAIT cycle (1-based) on which the ALU answers; 0 = never
    int bp;             // cycles rsp_ready stays low after rsp_valid
    logic exp_id, exp_err; logic [31:0] exp_data; int exp_lat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  // Behavioural ALU used as the stand-in responder.
  function automatic logic [31:0] stub(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    case (f)
      4'd0:    return {16'h0, a} + {16'h0, b};
      4'd1:    return {16'h0, a} * {16'h0, b};
      default: return {a, b};
    endcase
  endfunction

  // Runs one complete operation; returns what the DUT granted and responded.
  task automatic do_op(input logic v0, input logic v1,
                       input logic [15:0] a0, input logic [15:0] b0, input logic [3:0] f0,
                       input logic [15:0] a1, input logic [15:0] b1, input logic [3:0] f1,
                       input int dly, input int bp,
                       output logic g_id, output logic g_err, output logic [31:0] g_data, output int g_lat);
    int n, t, viol;
    logic [35:0] eop;
    g_id = 1'b0; g_err = 1'b0; g_data = '0; g_lat = -1; viol = 0;
    nxt();
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_fun = f0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_fun = f1;
    rsp_ready = 1'b0; alu_out_valid = 1'b0;
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 20) begin nxt(); #1; n++; end
    if (!(req0_ready || req1_ready)) begin
      chk("accept_wait", {req0_ready, req1_ready}, 2'b01);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    if (req0_ready && req1_ready) viol++;
    g_id = req1_ready;
    eop  = g_id ? {a1, b1, f1} : {a0, b0, f0};
    nxt();                                    // accept edge passed: ISSUE cycle
    if (g_id) req1_valid = 1'b0; else req0_valid = 1'b0;
    alu_out_valid = 1'b1; alu_out = 32'hDEADBEEF;   // must be ignored in ISSUE
    #1;
    chk("issue_en_busy", {alu_en, busy}, 2'b11);
    chk("issue_operands", {alu_a, alu_b, alu_fun}, eop);
    t = 1;
    do begin
      nxt(); t++;
      alu_out_valid = (t - 1 == dly);
      alu_out = alu_out_valid ? stub(eop[35:20], eop[19:4], eop[3:0]) : $urandom;
      #1;
      if (alu_en || !busy || req0_ready || req1_ready || {alu_a, alu_b, alu_fun} != eop) viol++;
    end while (!rsp_valid && t < 40);
    if (!rsp_valid) begin
      chk("rsp_wait", rsp_valid, 1'b1);
      alu_out_valid = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    g_lat = t; g_data = rsp_data; g_err = rsp_err;
    chk("rsp_id", rsp_id, g_id);
    for (int i = 0; i < bp; i++) begin
      nxt();
      alu_out_valid = 1'($urandom_range(0, 1)); alu_out = $urandom;
      #1;
      if (!rsp_valid || rsp_data !== g_data || rsp_err !== g_err || rsp_id !== g_id ||
          alu_en || req0_ready || req1_ready || !busy) viol++;
    end
    rsp_ready = 1'b1;
    nxt();                                    // handshake edge passed
    rsp_ready = 1'b0; alu_out_valid = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("rsp_release", {rsp_valid, busy}, 2'b00);
    chk("rsp_hold", {rsp_id, rsp_err, rsp_data}, {g_id, g_err, g_data});
    chk("op_protocol", viol, 0);
  endtask

  // Expected outcome from the rules: lone requester wins, contention follows the pointer,
  // a result inside the TIMEOUT window is returned, anything else becomes an error.
  task automatic model_op(input string tag, input logic v0, input logic v1,
                          input logic [15:0] a0, input logic [15:0] b0, input logic [3:0] f0,
                          input logic [15:0] a1, input logic [15:0] b1, input logic [3:0] f1,
                          input int dly, input int bp);
    logic eid, gid, gerr;
    logic [31:0] ed, gd;
    int el, gl;
    bit ok;
    eid = (v0 && v1) ? model_ptr : v1;
    ok  = (dly >= 1) && (dly <= TO);
    ed  = ok ? (eid ? stub(a1, b1, f1) : stub(a0, b0, f0)) : 32'h0;
    el  = ok ? dly + 2 : TO + 2;
    do_op(v0, v1, a0, b0, f0, a1, b1, f1, dly, bp, gid, gerr, gd, gl);
    chk({tag, "_id"}, gid, eid);
    chk({tag, "_err"}, gerr, !ok);
    chk({tag, "_data"}, gd, ed);
    chk({tag, "_lat"}, gl, el);
    model_ptr = ~eid;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic gid, gerr;
    logic [31:0] gd;
    logic [1:0] pat;
    logic exp_seq [4];
    int gl, viol6;

    RST = 1'b0; req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req0_fun = 0;
    req1_a = 0; req1_b = 0; req1_fun = 0; alu_out = 0; alu_out_valid = 0; rsp_ready = 0;
    model_ptr = 1'b0;

    // Reset held two cycles while every input toggles.
    for (int i = 0; i < 2; i++) begin
      nxt();
      req0_valid = 1'b1; req1_valid = 1'($urandom_range(0, 1));
      req0_a = 16'($urandom); req0_b = 16'($urandom); req0_fun = 4'($urandom);
      req1_a = 16'($urandom); req1_b = 16'($urandom); req1_fun = 4'($urandom);
      alu_out = $urandom; alu_out_valid = 1'($urandom_range(0, 1)); rsp_ready = 1'($urandom_range(0, 1));
      #1;
      chk("reset_alu", {alu_a, alu_b, alu_fun, alu_en}, 37'h0);
      chk("reset_rsp", {rsp_valid, rsp_id, rsp_data, rsp_err, busy, req0_ready, req1_ready}, 38'h0);
    end
    nxt();
    RST = 1'b1; req0_valid = 0; req1_valid = 0; alu_out_valid = 0; rsp_ready = 0;
    #1;
    chk("post_reset_idle", {busy, rsp_valid, alu_en}, 3'b000);

    // Directed table: single ops, alternation, timeout boundary.
    tbl[0] = '{1'b1, 1'b0, 16'd5, 16'd3, 4'd0, 16'd0, 16'd0, 4'd0, 1, 0, 1'b0, 1'b0, 32'd8, 3};
    tbl[1] = '{1'b0, 1'b1, 16'd0, 16'd0, 4'd0, 16'd100, 16'd200, 4'd1, 2, 0, 1'b1, 1'b0, 32'd20000, 4};
    tbl[2] = '{1'b1, 1'b1, 16'd7, 16'd9, 4'd0, 16'd2, 16'd3, 4'd1, 1, 2, 1'b0, 1'b0, 32'd16, 3};
    tbl[3] = '{1'b1, 1'b1, 16'd7, 16'd9, 4'd0, 16'd2, 16'd3, 4'd1, 3, 0, 1'b1, 1'b0, 32'd6, 5};
    tbl[4] = '{1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 4'd1, 16'd0, 16'd0, 4'd0, 15, 0, 1'b0, 1'b0, 32'hFFFE0001, 17};
    tbl[5] = '{1'b0, 1'b1, 16'd0, 16'd0, 4'd0, 16'hFFFF, 16'd1, 4'd0, 0, 1, 1'b1, 1'b1, 32'd0, 17};
    tbl[6] = '{1'b1, 1'b0, 16'h1234, 16'h5678, 4'd2, 16'd0, 16'd0, 4'd0, 16, 0, 1'b0, 1'b1, 32'd0, 17};
    tbl[7] = '{1'b1, 1'b1, 16'd1, 16'd1, 4'd0, 16'd3, 16'd4, 4'd1, 14, 0, 1'b1, 1'b0, 32'd12, 16};
    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].f0, tbl[i].a1, tbl[i].b1, tbl[i].f1,
            tbl[i].dly, tbl[i].bp, gid, gerr, gd, gl);
      chk($sformatf("vec%0d_id", i), gid, tbl[i].exp_id);
      chk($sformatf("vec%0d_err", i), gerr, tbl[i].exp_err);
      chk($sformatf("vec%0d_data", i), gd, tbl[i].exp_data);
      chk($sformatf("vec%0d_lat", i), gl, tbl[i].exp_lat);
      model_ptr = ~tbl[i].exp_id;
    end

    // Continuous contention from pointer 0: grants alternate 0,1,0,1.
    exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0; exp_seq[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, 1'b1, 16'(i), 16'd1, 4'd0, 16'(i), 16'd2, 4'd1, 1, 0, gid, gerr, gd, gl);
      chk($sformatf("contend%0d_id", i), gid, exp_seq[i]);
      model_ptr = ~exp_seq[i];
    end

    // Long backpressure with the other requester still asking.
    model_op("bp10", 1'b1, 1'b1, 16'd40, 16'd2, 4'd0, 16'd6, 16'd7, 4'd1, 2, 10);

    // Reset during WAIT, then a late ALU answer that must be dropped.
    nxt();
    req0_valid = 1'b1; req0_a = 16'd11; req0_b = 16'd22; req0_fun = 4'd0;
    #1;
    chk("rstwait_ready", req0_ready, 1'b1);
    nxt(); req0_valid = 1'b0; #1;
    chk("rstwait_issue", alu_en, 1'b1);
    nxt(); #1;
    RST = 1'b0;
    nxt(); RST = 1'b1; alu_out_valid = 1'b1; alu_out = 32'd33; #1;
    chk("rstwait_abort", {busy, rsp_valid, alu_en}, 3'b000);
    viol6 = 0;
    for (int i = 0; i < 6; i++) begin
      nxt(); alu_out_valid = 1'b0; #1;
      if (rsp_valid || busy) viol6++;
    end
    chk("rstwait_no_rsp", viol6, 0);
    model_ptr = 1'b0;
    model_op("after_rst", 1'b1, 1'b1, 16'd11, 16'd22, 4'd0, 16'd9, 16'd9, 4'd1, 1, 0);

    // Randomized operations against the model.
    for (int i = 0; i < 30; i++) begin
      int dly;
      pat = 2'($urandom_range(1, 3));
      dly = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 4) : $urandom_range(0, 18);
      model_op("rand", pat[0], pat[1],
               16'($urandom), 16'($urandom), 4'($urandom_range(0, 2)),
               16'($urandom), 16'($urandom), 4'($urandom_range(0, 2)),
               dly, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
